// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 Gaussian smoothing stage.
// Purpose: kernel shift amounts, normalisation constants and default widths
// used by conv3x3_gauss and its frame counter.
// Ports: none (package).
package conv_pkg;

  localparam int DEF_PIXEL_W = 8;

  // Kernel [1 2 1; 2 4 2; 1 2 1] is separable into a 1-2-1 row weight and a
  // 1-2-1 column weight, so every tap is a plain left shift.
  localparam int CENTRE_COL_SHIFT = 1;
  localparam int MID_ROW_SHIFT    = 1;

  localparam int NORM_SHIFT  = 4;
  localparam int ROUND_CONST = 8;
  localparam int SUM_W       = 12;

  // Shift applied to a whole row sum: the middle row carries double weight.
  function automatic int row_shift(input int row);
    return (row == 1) ? MID_ROW_SHIFT : 0;
  endfunction

endpackage

// File: rtl/frame_beat_counter.sv
// Counts output beats within a frame and flags the final beat.
// Purpose: tags the last beat of each frame and emits a one-cycle
// frame_done pulse on the cycle after that beat is transferred.
// Ports:
//   clk        clock
//   srst       synchronous active-high reset
//   beat       one completed output transfer this cycle
//   is_last    current beat index is the last one of the frame
//   frame_done registered pulse, high one cycle after the last beat
module frame_beat_counter #(
  parameter int TOTAL_BEATS = 512 * 512
) (
  input  logic clk,
  input  logic srst,
  input  logic beat,
  output logic is_last,
  output logic frame_done
);

  localparam int CNT_W = (TOTAL_BEATS > 1) ? $clog2(TOTAL_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(TOTAL_BEATS - 1);

  logic [CNT_W-1:0] count_reg;
  logic             frame_done_reg;

  assign is_last    = (count_reg == LAST_VAL);
  assign frame_done = frame_done_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg      <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= beat && is_last;
      if (beat) begin
        count_reg <= is_last ? '0 : count_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv3x3_gauss.sv
// Pipelined 3x3 Gaussian smoothing stage with AXI-Stream on both sides.
// Purpose: consumes one 3x3 window per beat, produces (weighted sum + 8) >> 4
// as one pixel per beat, tags the last pixel of each frame with tlast and
// pulses frame_done after it leaves.
// Ports:
//   s_aclk, s_areset          clock, synchronous active-high reset
//   s_axis_tvalid/tready/tdata window input, p0 at LSBs .. p8 at MSBs
//   m_axis_tvalid/tready/tdata filtered pixel output
//   m_axis_tlast              last pixel of a frame
//   frame_done                one-cycle pulse after the last pixel transfers
module conv3x3_gauss
  import conv_pkg::*;
#(
  parameter int PIXEL_W    = DEF_PIXEL_W,
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic                 s_aclk,
  input  logic                 s_areset,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [9*PIXEL_W-1:0] s_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [PIXEL_W-1:0]   m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic                 frame_done
);

  // Row sum: 1-2-1 gives up to 4*max, doubled for the middle row -> +3 bits.
  localparam int ROW_W = PIXEL_W + 3;
  // Total of weights is 16 -> +4 bits.
  localparam int TOT_W = PIXEL_W + 4;

  // The whole pipeline moves only when the output register can be emptied;
  // bubbles stay in place so all stages freeze together.
  logic advance;
  assign advance       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = advance && !s_areset;

  // ---------------- S1: weighted row sums ----------------
  logic [ROW_W-1:0] row_sum_next [3];
  logic [ROW_W-1:0] row_sum_reg  [3];
  logic             s1_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [ROW_W-1:0] left_px;
      logic [ROW_W-1:0] centre_px;
      logic [ROW_W-1:0] right_px;
      logic [ROW_W-1:0] row_raw;

      assign left_px   = ROW_W'(s_axis_tdata[(3*gi+0)*PIXEL_W +: PIXEL_W]);
      assign centre_px = ROW_W'(s_axis_tdata[(3*gi+1)*PIXEL_W +: PIXEL_W]);
      assign right_px  = ROW_W'(s_axis_tdata[(3*gi+2)*PIXEL_W +: PIXEL_W]);
      assign row_raw   = left_px + (centre_px << CENTRE_COL_SHIFT) + right_px;
      assign row_sum_next[gi] = row_raw << row_shift(gi);
    end
  endgenerate

  // ---------------- S2: total sum ----------------
  logic [TOT_W-1:0] total_next;
  logic [TOT_W-1:0] total_reg;
  logic             s2_valid_reg;

  assign total_next = TOT_W'(row_sum_reg[0]) + TOT_W'(row_sum_reg[1])
                    + TOT_W'(row_sum_reg[2]);

  // ---------------- S3: round, normalise, output register ----------------
  // Maximum total plus rounding still fits TOT_W bits, so no saturation.
  logic [TOT_W-1:0]   rounded;
  logic [PIXEL_W-1:0] pixel_next;
  logic [PIXEL_W-1:0] m_tdata_reg;
  logic               m_tvalid_reg;

  assign rounded    = total_reg + TOT_W'(ROUND_CONST);
  assign pixel_next = rounded[NORM_SHIFT +: PIXEL_W];

  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      m_tvalid_reg <= 1'b0;
      total_reg    <= '0;
      m_tdata_reg  <= '0;
      for (int i = 0; i < 3; i++) begin
        row_sum_reg[i] <= '0;
      end
    end else if (advance) begin
      s1_valid_reg <= s_axis_tvalid;
      s2_valid_reg <= s1_valid_reg;
      m_tvalid_reg <= s2_valid_reg;
      total_reg    <= total_next;
      m_tdata_reg  <= pixel_next;
      for (int i = 0; i < 3; i++) begin
        row_sum_reg[i] <= row_sum_next[i];
      end
    end
  end

  assign m_axis_tvalid = m_tvalid_reg;
  assign m_axis_tdata  = m_tdata_reg;

  // ---------------- frame tagging ----------------
  // The counter only moves on an output transfer, so tlast (derived from it)
  // is naturally stable while the output is stalled.
  logic beat;
  logic is_last;

  assign beat         = m_tvalid_reg && m_axis_tready;
  assign m_axis_tlast = m_tvalid_reg && is_last;

  frame_beat_counter #(
    .TOTAL_BEATS (IMG_WIDTH * IMG_HEIGHT)
  ) u_frame_beat_counter (
    .clk        (s_aclk),
    .srst       (s_areset),
    .beat       (beat),
    .is_last    (is_last),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_conv3x3_gauss.sv
// Scoreboard bench for conv3x3_gauss (4x2 frame). Inputs are driven on the
// falling edge; outputs are sampled 1 time unit after the falling edge.
module tb_conv3x3_gauss;

  localparam int PW     = 8;
  localparam int FRAME  = 8;   // 4 x 2

  logic          clk;
  logic          s_areset;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [9*PW-1:0] s_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [PW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          frame_done;

  conv3x3_gauss #(
    .PIXEL_W    (PW),
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (2)
  ) dut (
    .s_aclk        (clk),
    .s_areset      (s_areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .frame_done    (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   in_idx;
  int   checks;
  int   errors;
  int   rdy_mode;   // 0: always ready, 1: random, 2: held low
  bit   mon_en;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: weight of tap (r,c) is (1 + [r==1]) * (1 + [c==1]).
  function automatic int gauss_ref(input logic [9*PW-1:0] w);
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += ((r == 1) ? 2 : 1) * ((c == 1) ? 2 : 1) * int'(w[(3*r+c)*PW +: PW]);
    return (s + 8) / 16;
  endfunction

  function automatic logic [9*PW-1:0] make_win(input int p [9]);
    logic [9*PW-1:0] w;
    for (int i = 0; i < 9; i++) w[i*PW +: PW] = PW'(p[i]);
    return w;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_window(input logic [9*PW-1:0] w, input int exp_override);
    int t = 0;
    bit done = 0;
    exp_t e;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = w;
    while (!done) begin
      #1;
      if (s_axis_tready) begin
        e.data = (exp_override >= 0) ? exp_override : gauss_ref(w);
        e.last = ((in_idx % FRAME) == FRAME - 1);
        exp_q.push_back(e);
        in_idx++;
        done = 1;
      end
      @(negedge clk);
      t++;
      if (!done && t > 500) begin
        errors++;
        $display("FAIL input_accept_timeout: got no tready expected tready");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "input handshake timed out");
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    s_areset      = 1'b1;
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    in_idx = 0;
    #1;
    chk("tready_in_reset", int'(s_axis_tready), 0);
    repeat (cycles) @(negedge clk);
    s_areset = 1'b0;
    #1;
    chk("valid_after_reset", int'(m_axis_tvalid), 0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Ready generator
  always @(negedge clk) begin
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(0, 3) != 0);
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every output transfer, checks AXI-S
  // stability during stalls and the frame_done pulse.
  bit          prev_valid, prev_ready, prev_last, exp_fd;
  logic [PW-1:0] prev_data;
  always begin
    @(negedge clk);
    #1;
    if (s_areset || !mon_en) begin
      prev_valid = 0;
      exp_fd     = 0;
    end else begin
      exp_t e;
      bit hs;
      chk("frame_done", int'(frame_done), int'(exp_fd));
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", int'(m_axis_tvalid), 1);
        chk("stall_data", int'(m_axis_tdata), int'(prev_data));
        chk("stall_last", int'(m_axis_tlast), int'(prev_last));
      end
      hs = m_axis_tvalid && m_axis_tready;
      exp_fd = 0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data", int'(m_axis_tdata), e.data);
          chk("tlast", int'(m_axis_tlast), int'(e.last));
          exp_fd = e.last;
        end
      end
      prev_valid = m_axis_tvalid;
      prev_ready = m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  initial begin
    int p [9];
    logic [9*PW-1:0] w;
    checks = 0;
    errors = 0;
    in_idx = 0;
    rdy_mode = 0;
    mon_en = 0;
    s_areset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b1;

    do_reset(3);
    chk("reset_tdata", int'(m_axis_tdata), 0);
    chk("reset_tlast", int'(m_axis_tlast), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    mon_en = 1;

    // Flat window with latency check
    for (int i = 0; i < 9; i++) p[i] = 100;
    @(negedge clk);
    send_window(make_win(p), 100);
    #1 chk("flat_lat0", int'(m_axis_tvalid), 0);
    @(negedge clk); #1 chk("flat_lat1", int'(m_axis_tvalid), 0);
    @(negedge clk); #1 chk("flat_lat2_valid", int'(m_axis_tvalid), 1);
    chk("flat_lat2_data", int'(m_axis_tdata), 100);
    @(negedge clk); #1 chk("flat_one_cycle", int'(m_axis_tvalid), 0);

    // Impulse, corner, full-scale
    for (int i = 0; i < 9; i++) p[i] = 0;
    p[4] = 255;
    @(negedge clk);
    send_window(make_win(p), 64);
    p[4] = 0; p[0] = 255;
    send_window(make_win(p), 16);
    for (int i = 0; i < 9; i++) p[i] = 255;
    send_window(make_win(p), 255);
    p[0] = 0; p[8] = 0; p[4] = 0;
    send_window(make_win(p), -1);
    wait_drain();

    // Backpressure: 10 distinct windows, ready held low 5 cycles mid-stream
    do_reset(1);
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          for (int i = 0; i < 9; i++) p[i] = 20 * k + i;
          send_window(make_win(p), -1);
        end
      end
      begin
        repeat (4) @(negedge clk);
        rdy_mode = 2;
        repeat (5) @(negedge clk);
        rdy_mode = 0;
      end
    join
    wait_drain();

    // Frame tagging: 16 windows -> tlast on beats 8 and 16
    do_reset(1);
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 9; i++) p[i] = $urandom_range(0, 255);
      send_window(make_win(p), -1);
    end
    wait_drain();

    // Reset with two windows in flight
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 9; i++) p[i] = 200 - k;
      send_window(make_win(p), -1);
    end
    do_reset(1);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 9; i++) p[i] = $urandom_range(0, 255);
      send_window(make_win(p), -1);
    end
    wait_drain();

    // Random valid/ready over 1000 windows
    rdy_mode = 1;
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < 9; i++) p[i] = $urandom_range(0, 255);
      w = make_win(p);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_window(w, -1);
    end
    rdy_mode = 0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
